bumpy_teleporter: RTL and testbench

Consumes the packed destination byte produced by the teleport step tile (`teleport_cordinates`: [7:4] column index, [3:0] row index) when Bumpy collides with a teleport step. It freezes and hides Bumpy for a fixed number of frames, then issues a one-cycle position-load command with the destination pixel coordinates. A cooldown follows so that landing on the paired teleport does not bounce Bumpy straight back. It sits between the collision detector and the Bumpy move controller.

---
 rtl/bumpy_teleporter.sv | 145 ++++++++++++++
 tb/tb_bumpy_teleporter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bumpy_teleporter.sv
// rtl/bumpy_teleporter.sv - teleport sequencer: freeze/hide Bumpy, load destination, then cooldown
//
// Build option: define TELEPORT_BLINK_EN to make hide toggle on every frame while frozen.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-high reset
//   startOfFrame         one-cycle pulse per VGA frame
//   collision_tport      Bumpy overlaps a teleport step this cycle
//   teleport_cordinates  destination byte: [7:4] column, [3:0] row
//   freeze               Bumpy motion must hold
//   hide                 suppress Bumpy drawing request
//   load_pulse           one-cycle command to load newX/newY
//   newX, newY           destination top-left pixel coordinates
//   busy                 high whenever not idle
//   tport_count          completed teleports, saturating at 15
module bumpy_teleporter #(
  parameter int NUM_OF_COLS     = 10,
  parameter int NUM_OF_ROWS     = 7,
  parameter int TILE_SHIFT      = 6,
  parameter int LAND_OFFSET_X   = 16,
  parameter int LAND_OFFSET_Y   = 18,
  parameter int FREEZE_FRAMES   = 8,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        collision_tport,
  input  logic [7:0]  teleport_cordinates,
  output logic        freeze,
  output logic        hide,
  output logic        load_pulse,
  output logic [10:0] newX,
  output logic [10:0] newY,
  output logic        busy,
  output logic [3:0]  tport_count
);

  typedef enum logic [1:0] {IDLE, FREEZE, JUMP, COOLDOWN} state_t;

  state_t      state, state_next;
  logic [7:0]  frame_cnt, frame_cnt_next, cnt_inc;
  logic [3:0]  col, row, col_next, row_next;
  logic        coord_valid;
  logic        hide_next;
  logic [10:0] jump_x, jump_y;

  assign cnt_inc = frame_cnt + 8'd1;

  // Map filler bytes (e.g. 8'h09) fall outside the grid and mean "no destination".
  assign coord_valid = (32'(teleport_cordinates[7:4]) < NUM_OF_COLS) &&
                       (32'(teleport_cordinates[3:0]) < NUM_OF_ROWS);

  assign jump_x = (11'(col) << TILE_SHIFT) + 11'(LAND_OFFSET_X);
  assign jump_y = (11'(row) << TILE_SHIFT) + 11'(LAND_OFFSET_Y);

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    col_next       = col;
    row_next       = row;
    case (state)
      IDLE: begin
        // A coincident startOfFrame is not counted: the counter starts from zero.
        if (collision_tport && coord_valid) begin
          col_next       = teleport_cordinates[7:4];
          row_next       = teleport_cordinates[3:0];
          frame_cnt_next = 8'd0;
          state_next     = FREEZE;
        end
      end
      FREEZE: begin
        if (startOfFrame) begin
          frame_cnt_next = cnt_inc;
          if (cnt_inc == 8'(FREEZE_FRAMES)) begin
            state_next = JUMP;
          end
        end
      end
      JUMP: begin
        frame_cnt_next = 8'd0;
        state_next     = COOLDOWN;
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          frame_cnt_next = cnt_inc;
          if (cnt_inc == 8'(COOLDOWN_FRAMES)) begin
            frame_cnt_next = 8'd0;
            state_next     = IDLE;
          end
        end
      end
      default: begin
        frame_cnt_next = 8'd0;
        state_next     = IDLE;
      end
    endcase

`ifdef TELEPORT_BLINK_EN
    // Entering FREEZE starts visible-hidden at 1; each frame while frozen flips it.
    case (state_next)
      FREEZE:  hide_next = (state == FREEZE) ? (hide ^ startOfFrame) : 1'b1;
      JUMP:    hide_next = 1'b1;
      default: hide_next = 1'b0;
    endcase
`else
    hide_next = (state_next == FREEZE) || (state_next == JUMP);
`endif
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      col         <= 4'd0;
      row         <= 4'd0;
      freeze      <= 1'b0;
      hide        <= 1'b0;
      load_pulse  <= 1'b0;
      newX        <= 11'd0;
      newY        <= 11'd0;
      busy        <= 1'b0;
      tport_count <= 4'd0;
    end else begin
      state      <= state_next;
      frame_cnt  <= frame_cnt_next;
      col        <= col_next;
      row        <= row_next;
      freeze     <= (state_next == FREEZE) || (state_next == JUMP);
      hide       <= hide_next;
      load_pulse <= (state_next == JUMP);
      busy       <= (state_next != IDLE);
      if (state_next == JUMP) begin
        newX <= jump_x;
        newY <= jump_y;
        if (tport_count != 4'hF) begin
          tport_count <= tport_count + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bumpy_teleporter.sv
// tb/tb_bumpy_teleporter.sv - directed scoreboard bench for bumpy_teleporter
module tb_bumpy_teleporter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        collision_tport = 1'b0;
  logic [7:0]  teleport_cordinates = 8'h00;
  logic        freeze, hide, load_pulse, busy;
  logic [10:0] newX, newY;
  logic [3:0]  tport_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   model_cnt = 0;

  bumpy_teleporter dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .collision_tport     (collision_tport),
    .teleport_cordinates (teleport_cordinates),
    .freeze              (freeze),
    .hide                (hide),
    .load_pulse          (load_pulse),
    .newX                (newX),
    .newY                (newY),
    .busy                (busy),
    .tport_count         (tport_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Every load_pulse must match the oldest outstanding expected teleport.
  always @(negedge clk) begin
    if (!reset && load_pulse) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_newX", 32'(newX), 32'(mon_e.x));
        chk("sb_newY", 32'(newY), 32'(mon_e.y));
        chk("sb_count", 32'(tport_count), 32'(mon_e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two idle cycles then one startOfFrame cycle; returns 1ns after the counting edge.
  task automatic frame();
    tick();
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_t e;
    e.x = 11'(int'(b[7:4]) * 64 + 16);
    e.y = 11'(int'(b[3:0]) * 64 + 18);
    if (model_cnt < 15) model_cnt++;
    e.c = 4'(model_cnt);
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_freeze"}, 32'(freeze), 32'd0);
    chk({tag, "_hide"}, 32'(hide), 32'd0);
    chk({tag, "_load"}, 32'(load_pulse), 32'd0);
    chk({tag, "_newX"}, 32'(newX), 32'd0);
    chk({tag, "_newY"}, 32'(newY), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(tport_count), 32'd0);
  endtask

  // Full teleport; collide_at>0 injects a collision in that cooldown frame.
  task automatic teleport(input logic [7:0] b, input bit with_sof, input int collide_at,
                          input int hold_cycles);
    logic exp_hide;
    push_exp(b);
    collision_tport     = 1'b1;
    teleport_cordinates = b;
    startOfFrame        = with_sof;
    tick();
    startOfFrame = 1'b0;
    chk("entry_freeze", 32'(freeze), 32'd1);
    chk("entry_hide", 32'(hide), 32'd1);
    chk("entry_busy", 32'(busy), 32'd1);
    for (int k = 1; k < hold_cycles; k++) tick();
    collision_tport = 1'b0;
    for (int i = 1; i < 8; i++) begin
      frame();
`ifdef TELEPORT_BLINK_EN
      exp_hide = (i % 2 == 0);
`else
      exp_hide = 1'b1;
`endif
      chk("frozen_hide", 32'(hide), 32'(exp_hide));
      chk("frozen_freeze", 32'(freeze), 32'd1);
      chk("early_load", 32'(load_pulse), 32'd0);
    end
    frame();
    chk("jump_load", 32'(load_pulse), 32'd1);
    chk("jump_hide", 32'(hide), 32'd1);
    tick();
    chk("load_one_cycle", 32'(load_pulse), 32'd0);
    chk("cool_freeze", 32'(freeze), 32'd0);
    chk("cool_hide", 32'(hide), 32'd0);
    for (int i = 1; i <= 30; i++) begin
      if (i == 30) chk("cool_busy_29", 32'(busy), 32'd1);
      frame();
      if (i == collide_at) begin
        collision_tport     = 1'b1;
        teleport_cordinates = 8'h33;
        tick();
        collision_tport = 1'b0;
        chk("cool_coll_freeze", 32'(freeze), 32'd0);
        chk("cool_coll_busy", 32'(busy), 32'd1);
      end
    end
    chk("cool_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    check_zero("post_reset");

    // Basic teleport to column 7, row 6.
    teleport(8'h76, 1'b0, 0, 1);
    chk("count_1", 32'(tport_count), 32'd1);
    chk("hold_newX", 32'(newX), 32'd464);

    // Invalid bytes: row 9 and column 10.
    collision_tport     = 1'b1;
    teleport_cordinates = 8'h09;
    tick();
    teleport_cordinates = 8'hA0;
    tick();
    collision_tport = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("invalid_busy", 32'(busy), 32'd0);
      chk("invalid_freeze", 32'(freeze), 32'd0);
      tick();
    end

    // Collision held for 50 cycles: one teleport only.
    teleport(8'h16, 1'b0, 0, 50);
    // Collision in cooldown frame 10 ignored, then a fresh teleport.
    teleport(8'h21, 1'b0, 10, 1);
    teleport(8'h33, 1'b0, 0, 1);
    chk("count_4", 32'(tport_count), 32'd4);

    // Reset mid-freeze clears everything; no load follows.
    collision_tport     = 1'b1;
    teleport_cordinates = 8'h45;
    tick();
    collision_tport = 1'b0;
    for (int i = 0; i < 4; i++) frame();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    tick();
    reset = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 12; i++) frame();
    check_zero("after_reset");

    // 16 teleports: first with a coincident startOfFrame, one at the grid corner.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      if (n == 1) b = 8'h96;
      else b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 6))};
      teleport(b, (n == 0), 0, 1);
    end
    chk("count_saturated", 32'(tport_count), 32'd15);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
